// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution stage.
//   - 3-bit branch type encodings (BR_NONE .. BR_RSVD)
//   - 2-bit saturating counter encodings and the BHT reset value
//   - is_cond_br(): true for the types that train the BHT
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEZ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_JMP  = 3'b011,
    BR_BEQ  = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  localparam logic [1:0] CNT_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strongly taken

  localparam logic [1:0] BHT_RST_VAL = CNT_WNT;

  function automatic logic is_cond_br(input br_type_e t);
    return (t == BR_BEZ) || (t == BR_BNE) || (t == BR_BEQ) ||
           (t == BR_BLTZ) || (t == BR_BGEZ);
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Array of 2-bit saturating counters with one combinational read port and
// one saturating-update write port.
//   clk, rst_n  : clock, async active-low reset (all entries -> BHT_RST_VAL)
//   rd_idx      : read index; rd_pred = MSB of that counter (no write bypass)
//   upd_en      : update the counter at upd_idx this cycle
//   upd_taken   : count up (taken) or down (not taken), saturating
module bht_2bit
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_pred,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr [DEPTH];

  assign rd_pred = ctr[rd_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= BHT_RST_VAL;
    end else if (upd_en) begin
      if (upd_taken && ctr[upd_idx] != CNT_ST)
        ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
      else if (!upd_taken && ctr[upd_idx] != CNT_SNT)
        ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution at the ID/EX boundary. Evaluates the branch condition,
// compares it with the IF prediction and issues a one-cycle registered
// redirect on a mispredict. Keeps saturating branch/mispredict counters.
// Optional BHT (macro BRANCH_PREDICT_EN): 2-bit counters read by IF via
// if_pc -> if_pred_taken; without the macro if_pred_taken is tied 0.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   stall, id_valid              resolve event = id_valid && !stall
//   id_br_type, id_op_a/b        branch type and operands
//   id_pc, id_target             instruction PC and taken target
//   id_pred_taken                prediction carried from IF
//   if_pc / if_pred_taken        IF lookup into the BHT
//   redirect_valid/redirect_pc   registered redirect (pc holds when idle)
//   br_illegal                   registered reserved-type flag
//   br_count, mispredict_count   saturating performance counters
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              id_valid,
  input  logic [2:0]        id_br_type,
  input  logic [DATA_W-1:0] id_op_a,
  input  logic [DATA_W-1:0] id_op_b,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [PC_W-1:0]   id_target,
  input  logic              id_pred_taken,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              br_illegal,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  br_type_e br_type;
  logic     resolve;
  logic     actual_taken;
  logic     mispredict;
  logic     counted;

  assign br_type = br_type_e'(id_br_type);
  assign resolve = id_valid && !stall;

  always_comb begin
    actual_taken = 1'b0;
    case (br_type)
      BR_BEZ:  actual_taken = (id_op_a == '0);
      BR_BNE:  actual_taken = (id_op_a != id_op_b);
      BR_JMP:  actual_taken = 1'b1;
      BR_BEQ:  actual_taken = (id_op_a == id_op_b);
      BR_BLTZ: actual_taken = id_op_a[DATA_W-1];
      BR_BGEZ: actual_taken = !id_op_a[DATA_W-1];
      default: actual_taken = 1'b0;  // NONE and reserved never take
    endcase
  end

  assign mispredict = resolve && (actual_taken != id_pred_taken);
  assign counted    = resolve && (br_type != BR_NONE) && (br_type != BR_RSVD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      br_illegal       <= 1'b0;
      br_count         <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= mispredict;
      br_illegal     <= resolve && (br_type == BR_RSVD);
      if (mispredict) begin
        redirect_pc <= actual_taken ? id_target : id_pc + PC_W'(4);
        if (mispredict_count != '1) mispredict_count <= mispredict_count + CNT_W'(1);
      end
      if (counted && br_count != '1) br_count <= br_count + CNT_W'(1);
    end
  end

`ifdef BRANCH_PREDICT_EN
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_pred   (if_pred_taken),
    .upd_en    (resolve && is_cond_br(br_type)),
    .upd_idx   (id_pc[IDX_W+1:2]),
    .upd_taken (actual_taken)
  );
`else
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^if_pc;
  assign if_pred_taken     = 1'b0;
`endif

endmodule
